// File: rtl/alu_pkg.sv
// Shared op encodings and FSM state type for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SRAI = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W cycles
// including the start cycle; product is the low DATA_W bits of a*b.
module seq_mul #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] product,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              busy;

  // Bit 0 is consumed on the start edge so the last bit lands DATA_W-1 edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= b[0] ? a : '0;
        mcand   <= a << 1;
        mplier  <= b >> 1;
        cnt     <= CNT_W'(1);
        busy    <= 1'b1;
      end else if (busy) begin
        product <= product + (mplier[0] ? mcand : '0);
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        cnt     <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_alu.sv
// Valid/ready ALU with single-cycle ops and an optional iterative multiplier.
// Define PIPE_ALU_MUL_EN to build the multiplier; otherwise op 000 returns 0.
module pipe_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [2:0]        ALUCtrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              Zero_o
);

  state_t             state;
  logic               accept_c;
  logic [DATA_W-1:0]  alu_res_c;
  logic [SHAMT_W-1:0] shamt_c;

  assign shamt_c  = data2_i[SHAMT_W-1:0];
  assign accept_c = valid_i && ready_o;
  assign valid_o  = (state == ST_DONE);

  always_comb begin
    ready_o = 1'b0;
    case (state)
      ST_IDLE: ready_o = 1'b1;
      ST_DONE: ready_o = ready_i;
      default: ready_o = 1'b0;
    endcase
  end

  // Single-cycle datapath; OP_MUL falls to the default and yields 0 here.
  always_comb begin
    alu_res_c = '0;
    case (ALUCtrl_i)
      OP_SUB:  alu_res_c = data1_i - data2_i;
      OP_SRAI: alu_res_c = $signed(data1_i) >>> shamt_c;
      OP_AND:  alu_res_c = data1_i & data2_i;
      OP_ADD:  alu_res_c = data1_i + data2_i;
      OP_XOR:  alu_res_c = data1_i ^ data2_i;
      OP_SLL:  alu_res_c = data1_i << shamt_c;
      OP_OR:   alu_res_c = data1_i | data2_i;
      default: alu_res_c = '0;
    endcase
  end

`ifdef PIPE_ALU_MUL_EN
  logic              is_mul_c;
  logic [DATA_W-1:0] mul_product;
  logic              mul_done;

  assign is_mul_c = (ALUCtrl_i == OP_MUL);

  seq_mul #(.DATA_W(DATA_W)) u_seq_mul (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (accept_c && is_mul_c),
    .a       (data1_i),
    .b       (data2_i),
    .product (mul_product),
    .done    (mul_done)
  );
`endif

  // Control FSM; data_o/Zero_o only change when a new result is registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      data_o <= '0;
      Zero_o <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept_c) begin
`ifdef PIPE_ALU_MUL_EN
            if (is_mul_c) state <= ST_MUL;
            else
`endif
            begin
              data_o <= alu_res_c;
              Zero_o <= (alu_res_c == '0);
              state  <= ST_DONE;
            end
          end else if ((state == ST_DONE) && ready_i) begin
            state <= ST_IDLE;
          end
        end
`ifdef PIPE_ALU_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            data_o <= mul_product;
            Zero_o <= (mul_product == '0);
            state  <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
